// File: rtl/bnn_image_loader.sv
// bnn_image_loader: streams one frame of pixels into the bnn activation
// memory, kicks the core, then hands its activation result downstream.
module bnn_image_loader #(
  parameter int NUM_PIXELS     = 784,
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 8,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_pix_valid,
  output logic              s_pix_ready,
  input  logic [DATA_W-1:0] s_pix_data,
  input  logic              s_pix_last,
  output logic              bnn_wr_en,
  output logic [ADDR_W-1:0] bnn_wr_addr,
  output logic [DATA_W-1:0] bnn_wr_data,
  output logic              bnn_start,
  input  logic              bnn_done,
  input  logic [DATA_W-1:0] bnn_activation,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    LOAD, DRAIN, START, WAIT, RESULT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(NUM_PIXELS - 1);
  localparam logic [15:0] ST_N = 16'(START_CYCLES);
  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam logic [31:0] TO_LAST =
    TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [15:0] st_cnt;
  logic [31:0] to_cnt;
  logic accept, is_last_idx, timed_out;
  logic wr_en_n, start_n, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD:
        if (accept && is_last_idx)
          state_n = s_pix_last ? START : DRAIN;
      DRAIN:
        if (accept && s_pix_last) state_n = LOAD;
      START:
        if (st_cnt == ST_N) state_n = WAIT;
      WAIT:
        if (bnn_done)       state_n = RESULT;
        else if (timed_out) state_n = LOAD;
      RESULT:
        if (res_ready) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_comb begin
    s_pix_ready = (state == LOAD) || (state == DRAIN);
    busy        = state != LOAD;
    accept      = s_pix_valid && s_pix_ready;
    is_last_idx = cnt == LAST_IDX;
    timed_out   = TO_EN && (to_cnt == TO_LAST);
    wr_en_n     = accept && (state == LOAD);
    // start is registered, so it rises the cycle after the final write
    start_n     = (state == START) && (st_cnt < ST_N);
    err_n       = (wr_en_n && s_pix_last && !is_last_idx)
               || (state == DRAIN && accept && s_pix_last)
               || (state == WAIT && !bnn_done && timed_out);
    cnt_n = cnt;
    if (wr_en_n)
      cnt_n = (s_pix_last || is_last_idx) ? '0
                                          : cnt + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      st_cnt      <= '0;
      to_cnt      <= '0;
      bnn_wr_en   <= 1'b0;
      bnn_wr_addr <= '0;
      bnn_wr_data <= '0;
      bnn_start   <= 1'b0;
      frame_err   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      cnt       <= cnt_n;
      st_cnt    <= (state == START) ? st_cnt + 16'd1 : '0;
      to_cnt    <= (state == WAIT) ? to_cnt + 32'd1 : '0;
      bnn_wr_en <= wr_en_n;
      if (wr_en_n) begin
        bnn_wr_addr <= cnt;
        bnn_wr_data <= s_pix_data;
      end
      bnn_start <= start_n;
      frame_err <= err_n;
      if (state == WAIT && bnn_done) begin
        res_valid <= 1'b1;
        res_data  <= bnn_activation;
      end else if (state == RESULT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_image_loader.sv
// tb_bnn_image_loader: directed frames against a small bnn core model,
// checking writes, start timing, results, errors and reset behaviour.
module tb_bnn_image_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_pix_valid = 1'b0;
  logic s_pix_ready;
  logic [7:0] s_pix_data = '0;
  logic s_pix_last = 1'b0;
  logic bnn_wr_en;
  logic [10:0] bnn_wr_addr;
  logic [7:0] bnn_wr_data;
  logic bnn_start;
  logic bnn_done = 1'b0;
  logic [7:0] bnn_activation = '0;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [7:0] res_data;
  logic frame_err;
  logic busy;

  bnn_image_loader #(
    .NUM_PIXELS(784),
    .ADDR_W(11),
    .DATA_W(8),
    .START_CYCLES(2),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_pix_valid(s_pix_valid),
    .s_pix_ready(s_pix_ready),
    .s_pix_data(s_pix_data),
    .s_pix_last(s_pix_last),
    .bnn_wr_en(bnn_wr_en),
    .bnn_wr_addr(bnn_wr_addr),
    .bnn_wr_data(bnn_wr_data),
    .bnn_start(bnn_start),
    .bnn_done(bnn_done),
    .bnn_activation(bnn_activation),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // bnn core model: done rises 50 cycles after start and stays high
  bit model_on = 1'b1;
  bit drop_on_2nd = 1'b0;
  logic [7:0] act_val = '0;
  logic m_start_q = 1'b0;
  int tmr = 0;

  always @(posedge clk) begin
    m_start_q <= bnn_start;
    if (model_on && bnn_start && !m_start_q) begin
      bnn_done <= 1'b0;
      tmr <= 50;
    end else if (tmr == 1) begin
      bnn_done <= 1'b1;
      bnn_activation <= act_val;
      tmr <= 0;
    end else if (tmr > 1) begin
      tmr <= tmr - 1;
    end
    if (drop_on_2nd && bnn_start && m_start_q)
      bnn_done <= 1'b0;
  end

  // cumulative monitor, sampled on the falling edge
  int cyc = 0, wr_tot = 0, wr_bad = 0, start_tot = 0;
  int rise_tot = 0, err_tot = 0, rv_tot = 0, acc_tot = 0;
  int acc_base = 0;
  int rise_cyc = 0, fall_cyc = 0, err_cyc = 0, last_wr_cyc = 0;
  bit exp_wr = 1'b0;
  bit prev_start = 1'b0;
  logic [10:0] exp_addr = '0;
  logic [7:0] exp_data = '0;
  int idx;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_wr = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (bnn_wr_en !== exp_wr) wr_bad++;
      else if (exp_wr && (bnn_wr_addr !== exp_addr ||
                          bnn_wr_data !== exp_data)) wr_bad++;
      if (bnn_wr_en && bnn_start) wr_bad++;
      if (bnn_wr_en === 1'b1) begin
        wr_tot++;
        if (bnn_wr_addr == 11'd783) last_wr_cyc = cyc;
      end
      if (bnn_start === 1'b1) start_tot++;
      if (bnn_start === 1'b1 && !prev_start) begin
        rise_tot++;
        rise_cyc = cyc;
      end
      if (bnn_start === 1'b0 && prev_start) fall_cyc = cyc;
      prev_start = (bnn_start === 1'b1);
      if (frame_err === 1'b1) begin
        err_tot++;
        err_cyc = cyc;
      end
      if (res_valid === 1'b1) rv_tot++;
      exp_wr = 1'b0;
      if (s_pix_valid && s_pix_ready === 1'b1) begin
        idx = acc_tot - acc_base;
        if (idx < 784) begin
          exp_wr = 1'b1;
          exp_addr = 11'(idx);
          exp_data = s_pix_data;
        end
        acc_tot++;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int n, input int last_at,
                            input bit bub);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (bub && $urandom_range(0, 2) == 0 && t < 8) begin
        s_pix_valid = 1'b0;
        tick(1);
        t++;
      end
      s_pix_valid = 1'b1;
      s_pix_data = i[7:0];
      s_pix_last = (i == last_at);
      t = 0;
      while (s_pix_ready !== 1'b1 && t < 5000) begin
        tick(1);
        t++;
      end
      if (t >= 5000) begin
        chk("pix_ready_timeout", 32'(i), 32'(n));
        break;
      end
      tick(1);
    end
    s_pix_valid = 1'b0;
    s_pix_last = 1'b0;
  endtask

  task automatic wait_res();
    int t = 0;
    while (res_valid !== 1'b1 && t < 3000) begin
      tick(1);
      t++;
    end
    chk("res_valid_seen", 32'(res_valid), 32'd1);
  endtask

  task automatic good_frame(input bit bub, input logic [7:0] act,
                            input int hold);
    int b_wr, b_bad, b_rise, b_st, b_err, hbad;
    act_val = act;
    b_wr = wr_tot; b_bad = wr_bad; b_rise = rise_tot;
    b_st = start_tot; b_err = err_tot;
    acc_base = acc_tot;
    send_frame(784, 783, bub);
    wait_res();
    chk("res_data", 32'(res_data), 32'(act));
    hbad = 0;
    repeat (hold) begin
      tick(1);
      if (res_valid !== 1'b1 || res_data !== act ||
          s_pix_ready !== 1'b0) hbad++;
    end
    chk("result_hold", 32'(hbad), 32'd0);
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    chk("res_valid_clr", 32'(res_valid), 32'd0);
    chk("busy_after_res", 32'(busy), 32'd0);
    chk("wr_count", 32'(wr_tot - b_wr), 32'd784);
    chk("wr_seq", 32'(wr_bad - b_bad), 32'd0);
    chk("start_rises", 32'(rise_tot - b_rise), 32'd1);
    chk("start_cycles", 32'(start_tot - b_st), 32'd2);
    chk("start_after_wr", 32'(rise_cyc - last_wr_cyc), 32'd1);
    chk("no_err", 32'(err_tot - b_err), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int b_wr, b_bad, b_rise, b_err, b_rv, b_acc, t;

  initial begin
    // reset state
    tick(2);
    chk("rst_ctrl", 32'({bnn_wr_en, bnn_start, res_valid,
                         frame_err, busy}), 32'd0);
    chk("rst_wdata", 32'({bnn_wr_addr, bnn_wr_data, res_data}),
        32'd0);
    chk("rst_ready", 32'(s_pix_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    // clean frame, then bubbles with delayed consumer
    good_frame(1'b0, 8'h05, 0);
    good_frame(1'b1, 8'h3c, 10);

    // early last on beat 99
    b_wr = wr_tot; b_bad = wr_bad; b_rise = rise_tot;
    b_err = err_tot; acc_base = acc_tot;
    send_frame(100, 99, 1'b0);
    tick(3);
    chk("early_wr", 32'(wr_tot - b_wr), 32'd100);
    chk("early_seq", 32'(wr_bad - b_bad), 32'd0);
    chk("early_err", 32'(err_tot - b_err), 32'd1);
    chk("early_nostart", 32'(rise_tot - b_rise), 32'd0);
    chk("early_busy", 32'(busy), 32'd0);
    good_frame(1'b0, 8'h11, 0);

    // overlong frame: 790 beats
    b_wr = wr_tot; b_bad = wr_bad; b_rise = rise_tot;
    b_err = err_tot; acc_base = acc_tot;
    send_frame(790, 789, 1'b0);
    tick(3);
    chk("long_wr", 32'(wr_tot - b_wr), 32'd784);
    chk("long_acc", 32'(acc_tot - acc_base), 32'd790);
    chk("long_seq", 32'(wr_bad - b_bad), 32'd0);
    chk("long_err", 32'(err_tot - b_err), 32'd1);
    chk("long_nostart", 32'(rise_tot - b_rise), 32'd0);
    chk("long_busy", 32'(busy), 32'd0);

    // stale done through START, then timeout in WAIT
    model_on = 1'b0;
    drop_on_2nd = 1'b1;
    b_rise = rise_tot; b_err = err_tot; b_rv = rv_tot;
    acc_base = acc_tot;
    send_frame(784, 783, 1'b0);
    t = 0;
    while (err_tot == b_err && t < 1300) begin
      tick(1);
      t++;
    end
    tick(3);
    chk("to_start", 32'(rise_tot - b_rise), 32'd1);
    chk("to_err", 32'(err_tot - b_err), 32'd1);
    chk("to_delay", 32'(err_cyc - fall_cyc), 32'd1000);
    chk("to_nores", 32'(rv_tot - b_rv), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    model_on = 1'b1;
    drop_on_2nd = 1'b0;

    // reset right after beat 400 is accepted
    acc_base = acc_tot;
    send_frame(401, -1, 1'b0);
    chk("pre_rst_wr", 32'(bnn_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_load_ctrl", 32'({bnn_wr_en, bnn_start, res_valid,
                              frame_err, busy}), 32'd0);
    chk("rst_load_data", 32'({bnn_wr_addr, bnn_wr_data,
                              res_data}), 32'd0);
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    // reset while waiting for done
    act_val = 8'h77;
    acc_base = acc_tot;
    send_frame(784, 783, 1'b0);
    tick(10);
    chk("wait_busy", 32'({busy, res_valid}), 32'b10);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ctrl", 32'({bnn_wr_en, bnn_start, res_valid,
                              frame_err, busy}), 32'd0);
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(2);
    good_frame(1'b0, 8'ha5, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
